mode_switch_controller: RTL and testbench
=========================================

MODE_SWITCH_CONTROLLER -- requirements
Module: mode_switch_controller

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 50000, meaning clk cycles a new mode selection must hold before it is accepted.
REQ-002 SHALL have parameter BLANK_FRAMES, default 2, meaning frame_begin pulses of forced-black output before the new mode is granted.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the BLANK watchdog limit; used only when MODE_CTRL_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port resn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mode_sel, input, 3, raw mode switches: 000 home, 001 basic, 010 graph, 100 game; any other code decodes to home.
REQ-007 SHALL have port frame_begin, input, 1, single-cycle frame-start pulse from the OLED driver.
REQ-008 SHALL have port btn_in, input, 5, debounced button pulses {C,U,L,R,D}.
REQ-009 SHALL have port mode, output, 2, granted mode: 00 home, 01 basic, 10 graph, 11 game.
REQ-010 SHALL have port btn_out, output, 5, btn_in passed through only while in RUN, else 0.
REQ-011 SHALL have port blank, output, 1; high forces both screens black.
REQ-012 SHALL have port mode_changed, output, 1, single-cycle pulse when mode updates.
REQ-013 SHALL have port timeout_flag, output, 1, sticky watchdog flag; constant 0 when the feature is compiled out.

Function
REQ-014 SHALL implement states RUN, PENDING, BLANK and SWITCH, with all outputs registered.
REQ-015 In RUN: if decoded mode_sel differs from mode, SHALL latch it as target, clear the stability counter and enter PENDING next cycle.
REQ-016 In PENDING: SHALL count cycles while decoded mode_sel equals target.
- Decoded value changes to another non-current mode: reload target, restart count.
- Decoded value returns to current mode: abort to RUN, no blank, no pulse.
- Count reaches STABLE_CYCLES: enter BLANK.
REQ-017 In BLANK: blank=1; SHALL count frame_begin pulses, then enter SWITCH after BLANK_FRAMES pulses; mode_sel changes are ignored.
REQ-018 In SWITCH, lasting one cycle: mode<=target and mode_changed=1, with blank still 1; the next cycle SHALL be RUN with blank=0.
REQ-019 After returning to RUN, a mode_sel mismatch SHALL start a fresh PENDING with no merge of earlier requests.
REQ-020 btn_out SHALL be 0 from the first PENDING cycle through SWITCH; a button pulse coincident with the RUN->PENDING decision is passed, since the state is still RUN.
REQ-021 A frame_begin coincident with BLANK entry SHALL NOT be counted.
REQ-022 Counters SHALL saturate, with no wrap-around; widths are sized by $clog2 of the parameters.

Reset
REQ-023 Asserting resn low SHALL immediately force RUN, mode=00, btn_out=0, blank=0, mode_changed=0, timeout_flag=0 and all counters 0, including mid-PENDING or mid-BLANK.
REQ-024 After resn deasserts, a non-home mode_sel SHALL be handled as a normal RUN mismatch.

Configuration
REQ-025 Macro MODE_CTRL_TIMEOUT_EN defined: a BLANK cycle counter runs, and reaching TIMEOUT_CYCLES without completing BLANK_FRAMES forces SWITCH and sets timeout_flag until reset.
REQ-026 Macro MODE_CTRL_TIMEOUT_EN undefined: BLANK waits indefinitely for frame_begin, and timeout_flag is tied to 0.

Verification
Bench parameters: STABLE_CYCLES=4, BLANK_FRAMES=2, TIMEOUT_CYCLES=20.
REQ-027 mode_sel 000->001 held, frame_begin every 10 cycles -> PENDING 4 cycles, blank=1 until the 2nd counted pulse, mode=01 with a 1-cycle mode_changed, then blank=0.
REQ-028 mode_sel 001 for 2 cycles then back to 000 -> no blank, no mode_changed, mode stays 00.
REQ-029 mode_sel 001 for 2 cycles then 010 held -> target reloads, final mode=10 exactly once.
REQ-030 mode_sel 011 while mode=01 -> decodes to home, and the switch ends with mode=00.
REQ-031 btn_in=5'b10000 pulsed during BLANK -> btn_out=0; the same pulse in RUN -> btn_out=5'b10000 on the next cycle.
REQ-032 resn low mid-BLANK -> mode=00, blank=0 at once. With the macro defined and no frame_begin: SWITCH after 20 cycles and timeout_flag=1.

Source files
------------

// File: rtl/mode_switch_controller.sv
// -----------------------------------------------------------------------------
// mode_switch_controller
//
// Purpose: accepts a raw mode-selection switch and changes the granted display
// mode cleanly. A new selection must be held for STABLE_CYCLES clocks, then
// both screens are forced black for BLANK_FRAMES frame_begin pulses, then the
// mode is updated with a one-cycle mode_changed pulse. Buttons are passed
// through only while the controller is idle in RUN.
//
// Ports:
//   clk           in   sole clock, rising edge
//   resn          in   asynchronous active-low reset
//   mode_sel[2:0] in   raw switches: 000 home, 001 basic, 010 graph, 100 game,
//                      any other code decodes to home
//   frame_begin   in   single-cycle frame-start pulse from the OLED driver
//   btn_in[4:0]   in   debounced button pulses {C,U,L,R,D}
//   mode[1:0]     out  granted mode: 00 home, 01 basic, 10 graph, 11 game
//   btn_out[4:0]  out  btn_in, registered, only while in RUN; else 0
//   blank         out  high forces both screens black
//   mode_changed  out  single-cycle pulse when mode updates
//   timeout_flag  out  sticky BLANK watchdog flag
//
// Optional feature: define MODE_CTRL_TIMEOUT_EN to add a BLANK watchdog. If
// BLANK lasts TIMEOUT_CYCLES clocks without the required frame_begin pulses,
// the switch is forced and timeout_flag stays set until reset. Without the
// macro BLANK waits indefinitely and timeout_flag is tied to 0.
// -----------------------------------------------------------------------------
module mode_switch_controller #(
    parameter int STABLE_CYCLES  = 50000,
    parameter int BLANK_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resn,
    input  logic [2:0] mode_sel,
    input  logic       frame_begin,
    input  logic [4:0] btn_in,
    output logic [1:0] mode,
    output logic [4:0] btn_out,
    output logic       blank,
    output logic       mode_changed,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PENDING,
        ST_BLANK,
        ST_SWITCH
    } state_e;

    // Counters only ever need to reach PARAM-1 before the state moves on.
    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int FC_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLANK_FRAMES - 1);

    state_e            state_q, state_d;
    logic [1:0]        target_q, target_d;
    logic [SC_W-1:0]   stable_cnt_q, stable_cnt_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [4:0]        btn_out_q, btn_out_d;
    logic              blank_q, blank_d;
    logic              mode_changed_q, mode_changed_d;
    logic [1:0]        sel_mode;

`ifdef MODE_CTRL_TIMEOUT_EN
    localparam int TC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);

    logic [TC_W-1:0]   blank_cyc_q, blank_cyc_d;
    logic              timeout_flag_q, timeout_flag_d;
`else
    // Keeps the parameter referenced in builds without the watchdog.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    function automatic logic [1:0] decode_mode(input logic [2:0] sel);
        case (sel)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    assign sel_mode = decode_mode(mode_sel);

    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // that no path leaves it unassigned; otherwise a latch is inferred.
        state_d        = state_q;
        target_d       = target_q;
        stable_cnt_d   = stable_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        mode_d         = mode_q;
        mode_changed_d = 1'b0;
        // Uses the current state, so a pulse arriving on the RUN->PENDING
        // decision cycle is still passed.
        btn_out_d      = (state_q == ST_RUN) ? btn_in : 5'b0;
`ifdef MODE_CTRL_TIMEOUT_EN
        blank_cyc_d    = blank_cyc_q;
        timeout_flag_d = timeout_flag_q;
`endif

        case (state_q)
            ST_RUN: begin
                if (sel_mode != mode_q) begin
                    target_d     = sel_mode;
                    stable_cnt_d = '0;
                    state_d      = ST_PENDING;
                end
            end

            ST_PENDING: begin
                if (sel_mode == mode_q) begin
                    // Selection went back to the current mode: silent abort.
                    stable_cnt_d = '0;
                    state_d      = ST_RUN;
                end else if (sel_mode != target_q) begin
                    target_d     = sel_mode;
                    stable_cnt_d = '0;
                end else if (stable_cnt_q == SC_LAST) begin
                    // Frame counting starts in BLANK itself, so a frame_begin
                    // on this entry cycle is never counted.
                    frame_cnt_d = '0;
`ifdef MODE_CTRL_TIMEOUT_EN
                    blank_cyc_d = '0;
`endif
                    state_d     = ST_BLANK;
                end else begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end

            ST_BLANK: begin
                if (frame_begin) begin
                    if (frame_cnt_q == FC_LAST) begin
                        state_d = ST_SWITCH;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
`ifdef MODE_CTRL_TIMEOUT_EN
                // A frame completion on the same cycle wins over the watchdog.
                if (state_d != ST_SWITCH) begin
                    if (blank_cyc_q == TC_LAST) begin
                        state_d        = ST_SWITCH;
                        timeout_flag_d = 1'b1;
                    end else begin
                        blank_cyc_d = blank_cyc_q + 1'b1;
                    end
                end
`endif
            end

            ST_SWITCH: begin
                stable_cnt_d = '0;
                frame_cnt_d  = '0;
                state_d      = ST_RUN;
            end

            default: state_d = ST_RUN;
        endcase

        // Outputs are computed from the next state so that, once registered,
        // they line up with the state they describe.
        if (state_d == ST_SWITCH) begin
            mode_d         = target_q;
            mode_changed_d = 1'b1;
        end
        blank_d = (state_d == ST_BLANK) || (state_d == ST_SWITCH);
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q        <= ST_RUN;
            target_q       <= 2'b00;
            stable_cnt_q   <= '0;
            frame_cnt_q    <= '0;
            mode_q         <= 2'b00;
            btn_out_q      <= 5'b0;
            blank_q        <= 1'b0;
            mode_changed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q        <= state_d;
            target_q       <= target_d;
            stable_cnt_q   <= stable_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            mode_q         <= mode_d;
            btn_out_q      <= btn_out_d;
            blank_q        <= blank_d;
            mode_changed_q <= mode_changed_d;
        end
    end

`ifdef MODE_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            blank_cyc_q    <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            blank_cyc_q    <= blank_cyc_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign mode         = mode_q;
    assign btn_out      = btn_out_q;
    assign blank        = blank_q;
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_mode_switch_controller.sv
// -----------------------------------------------------------------------------
// tb_mode_switch_controller
//
// Directed bench for mode_switch_controller with STABLE_CYCLES=4,
// BLANK_FRAMES=2, TIMEOUT_CYCLES=20. A vector table walks one full switch
// cycle by cycle; hand-written sequences cover abort, retarget, decode of an
// illegal code, reset in BLANK and the BLANK watchdog (MODE_CTRL_TIMEOUT_EN).
// Outputs are compared as one packed word:
//   {mode[1:0], btn_out[4:0], blank, mode_changed, timeout_flag}
// -----------------------------------------------------------------------------
module tb_mode_switch_controller;

    logic       clk;
    logic       resn;
    logic [2:0] mode_sel;
    logic       frame_begin;
    logic [4:0] btn_in;
    logic [1:0] mode;
    logic [4:0] btn_out;
    logic       blank;
    logic       mode_changed;
    logic       timeout_flag;

    int n_checks;
    int n_passed;
    int mc_pulses;
    int blank_seen;

    mode_switch_controller #(
        .STABLE_CYCLES (4),
        .BLANK_FRAMES  (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk         (clk),
        .resn        (resn),
        .mode_sel    (mode_sel),
        .frame_begin (frame_begin),
        .btn_in      (btn_in),
        .mode        (mode),
        .btn_out     (btn_out),
        .blank       (blank),
        .mode_changed(mode_changed),
        .timeout_flag(timeout_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] sel;
        logic       fb;
        logic [4:0] btn;
        logic [1:0] exp_mode;
        logic [4:0] exp_btn;
        logic       exp_blank;
        logic       exp_mc;
    } vec_t;

    function automatic logic [9:0] outs();
        return {mode, btn_out, blank, mode_changed, timeout_flag};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        else
            n_passed++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_passed++;
    endtask

    // Sample 1 time unit after the rising edge, away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds sel for n cycles; frame_begin pulses on every fb_period-th cycle
    // (0 = never). Tallies mode_changed pulses and blanked cycles.
    task automatic run(input int n, input logic [2:0] sel, input int fb_period);
        for (int k = 0; k < n; k++) begin
            mode_sel    = sel;
            frame_begin = (fb_period > 0) && ((k % fb_period) == fb_period - 1);
            tick();
            if (mode_changed) mc_pulses++;
            if (blank) blank_seen++;
        end
        frame_begin = 1'b0;
    endtask

    task automatic do_reset();
        resn        = 1'b0;
        mode_sel    = 3'b000;
        frame_begin = 1'b0;
        btn_in      = 5'b0;
        repeat (2) tick();
        resn       = 1'b1;
        mc_pulses  = 0;
        blank_seen = 0;
    endtask

    vec_t vecs[11];

    initial begin
        n_checks    = 0;
        n_passed    = 0;
        mc_pulses   = 0;
        blank_seen  = 0;
        resn        = 1'b0;
        mode_sel    = 3'b000;
        frame_begin = 1'b0;
        btn_in      = 5'b0;

        // Full 000 -> 001 switch, one record per clock.
        //          sel     fb    btn        mode   btn_out   blank mc
        vecs[0]  = '{3'b001, 1'b0, 5'b00001, 2'b00, 5'b00001, 1'b0, 1'b0}; // decision cycle: btn passes
        vecs[1]  = '{3'b001, 1'b0, 5'b00010, 2'b00, 5'b00000, 1'b0, 1'b0}; // PENDING blocks btn
        vecs[2]  = '{3'b001, 1'b0, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0};
        vecs[3]  = '{3'b001, 1'b0, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 1'b1, 5'b00000, 2'b00, 5'b00000, 1'b1, 1'b0}; // BLANK entry, fb ignored
        vecs[5]  = '{3'b100, 1'b1, 5'b00000, 2'b00, 5'b00000, 1'b1, 1'b0}; // 1st frame; sel change ignored
        vecs[6]  = '{3'b001, 1'b0, 5'b10000, 2'b00, 5'b00000, 1'b1, 1'b0}; // btn blocked in BLANK
        vecs[7]  = '{3'b001, 1'b1, 5'b00000, 2'b01, 5'b00000, 1'b1, 1'b1}; // 2nd frame -> SWITCH
        vecs[8]  = '{3'b001, 1'b0, 5'b10000, 2'b01, 5'b00000, 1'b0, 1'b0}; // btn blocked in SWITCH
        vecs[9]  = '{3'b001, 1'b0, 5'b10000, 2'b01, 5'b10000, 1'b0, 1'b0}; // RUN passes btn
        vecs[10] = '{3'b001, 1'b0, 5'b00000, 2'b01, 5'b00000, 1'b0, 1'b0};

        // Reset state, observed while reset is held.
        #2;
        check("reset_state", outs(), 10'b0);
        do_reset();
        check("after_reset_release", outs(), 10'b0);

        for (int i = 0; i < 11; i++) begin
            mode_sel    = vecs[i].sel;
            frame_begin = vecs[i].fb;
            btn_in      = vecs[i].btn;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].exp_mode, vecs[i].exp_btn, vecs[i].exp_blank, vecs[i].exp_mc, 1'b0});
        end
        btn_in      = 5'b0;
        frame_begin = 1'b0;

        // Short request that returns to the current mode: silent abort.
        do_reset();
        run(2, 3'b001, 0);
        run(10, 3'b000, 0);
        check_int("abort_blank_cycles", blank_seen, 0);
        check_int("abort_mc_pulses", mc_pulses, 0);
        check("abort_outputs", outs(), 10'b0);

        // Request retargeted before it settles: only the final target lands.
        do_reset();
        run(2, 3'b001, 0);
        run(60, 3'b010, 10);
        check_int("retarget_mc_pulses", mc_pulses, 1);
        check("retarget_outputs", outs(), {2'b10, 5'b0, 1'b0, 1'b0, 1'b0});

        // Illegal code 011 decodes to home.
        do_reset();
        run(40, 3'b001, 10);
        check("to_basic", outs(), {2'b01, 5'b0, 3'b000});
        mc_pulses = 0;
        run(40, 3'b011, 10);
        check_int("illegal_code_mc_pulses", mc_pulses, 1);
        check("illegal_code_home", outs(), 10'b0);

        // Reset asserted mid-BLANK clears outputs without a clock edge.
        do_reset();
        run(40, 3'b001, 10);
        run(6, 3'b010, 0);
        check("mid_blank", outs(), {2'b01, 5'b0, 1'b1, 1'b0, 1'b0});
        resn = 1'b0;
        #1;
        check("reset_mid_blank", outs(), 10'b0);
        tick();
        resn      = 1'b1;
        mc_pulses = 0;
        // Non-home selection after reset is a normal request.
        run(40, 3'b010, 10);
        check_int("post_reset_mc_pulses", mc_pulses, 1);
        check("post_reset_switch", outs(), {2'b10, 5'b0, 3'b000});

        // BLANK with no frame_begin at all.
        do_reset();
`ifdef MODE_CTRL_TIMEOUT_EN
        // Entry on cycle 5, 20 BLANK cycles, forced SWITCH on cycle 25.
        run(24, 3'b001, 0);
        check("timeout_pre", outs(), {2'b00, 5'b0, 1'b1, 1'b0, 1'b0});
        run(1, 3'b001, 0);
        check("timeout_switch", outs(), {2'b01, 5'b0, 1'b1, 1'b1, 1'b1});
        run(1, 3'b001, 0);
        check("timeout_sticky", outs(), {2'b01, 5'b0, 1'b0, 1'b0, 1'b1});
`else
        run(40, 3'b001, 0);
        check("no_frames_waits", outs(), {2'b00, 5'b0, 1'b1, 1'b0, 1'b0});
        check_int("no_frames_mc_pulses", mc_pulses, 0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
